// File: rtl/teclado_digitos.sv
// Keypad digit accumulator: collects BCD digits into a shift buffer and emits a
// one-cycle final value on confirm, cancel or inactivity timeout.
module teclado_digitos #(
    parameter int TIMEOUT_CYCLES = 250_000_000,
    parameter int MAX_DIGITS     = 20
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                key_valid,
    input  logic [3:0]                          key_code,
    output logic [4*MAX_DIGITS-1:0]             digitos_value,
    output logic                                digitos_valid,
    output logic [$clog2(MAX_DIGITS+1)-1:0]     digit_count
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [4*MAX_DIGITS-1:0] ALL_F = {MAX_DIGITS{4'hF}};
    localparam logic [4*MAX_DIGITS-1:0] ALL_B = {MAX_DIGITS{4'hB}};
    localparam logic [4*MAX_DIGITS-1:0] ALL_E = {MAX_DIGITS{4'hE}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   timer;

    logic is_digit, is_confirm, is_cancel;

    always_comb begin
        is_digit   = key_valid && (key_code <= 4'd9);
        is_confirm = key_valid && (key_code == 4'hA);
        is_cancel  = key_valid && (key_code == 4'hB);
    end

    // The output buffer doubles as the entry buffer; sentinel patterns are
    // loaded into it for the single EMIT cycle and then wiped back to all-F.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            digitos_value <= ALL_F;
            digitos_valid <= 1'b0;
            digit_count   <= '0;
            timer         <= '0;
        end else begin
            digitos_valid <= 1'b0;
            case (state)
                IDLE, ENTRY: begin
                    if (is_digit) begin
                        digitos_value <= {digitos_value[4*MAX_DIGITS-5:0], key_code};
                        if (digit_count != CNT_W'(MAX_DIGITS))
                            digit_count <= digit_count + CNT_W'(1);
                        state <= ENTRY;
                        timer <= '0;
                    end else if (is_confirm) begin
                        if (state == IDLE)
                            digitos_value <= ALL_F;
                        digitos_valid <= 1'b1;
                        state         <= EMIT;
                        timer         <= '0;
                    end else if (is_cancel) begin
                        digitos_value <= ALL_B;
                        digitos_valid <= 1'b1;
                        state         <= EMIT;
                        timer         <= '0;
                    end else if (state == ENTRY) begin
                        // A key in the expiry cycle wins, so expiry is only checked here.
                        if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                            digitos_value <= ALL_E;
                            digitos_valid <= 1'b1;
                            state         <= EMIT;
                            timer         <= '0;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end else begin
                        timer <= '0;
                    end
                end
                EMIT: begin
                    digitos_value <= ALL_F;
                    digit_count   <= '0;
                    state         <= IDLE;
                    timer         <= '0;
                end
                default: begin
                    digitos_value <= ALL_F;
                    digit_count   <= '0;
                    state         <= IDLE;
                    timer         <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_teclado_digitos.sv
// Directed bench for teclado_digitos: vector table for the main entry flow plus
// hand-written sequences for timeout, saturation, EMIT drop and async reset.
module tb_teclado_digitos;

    localparam int T = 16;

    localparam logic [79:0] ALL_F = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [79:0] ALL_B = 80'hBBBB_BBBB_BBBB_BBBB_BBBB;
    localparam logic [79:0] ALL_E = 80'hEEEE_EEEE_EEEE_EEEE_EEEE;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [79:0] digitos_value;
    logic        digitos_valid;
    logic [4:0]  digit_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    teclado_digitos #(.TIMEOUT_CYCLES(T), .MAX_DIGITS(20)) dut (
        .clk           (clk),
        .rst           (rst),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .digitos_value (digitos_value),
        .digitos_valid (digitos_valid),
        .digit_count   (digit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          gap;
        bit          press;
        logic [3:0]  code;
        logic [79:0] val;
        logic [4:0]  cnt;
        logic        vld;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check_all(input string nm, input logic [79:0] v, input logic [4:0] c, input logic vl);
        check({nm, ".value"}, digitos_value, v);
        check({nm, ".count"}, 80'(digit_count), 80'(c));
        check({nm, ".valid"}, 80'(digitos_valid), 80'(vl));
    endtask

    // Strobe one key for exactly one clock; returns at the negedge after acceptance.
    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    initial begin
        vecs[0]  = '{0, 1'b1, 4'h1, 80'hFFFF_FFFF_FFFF_FFFF_FFF1, 5'd1, 1'b0};
        vecs[1]  = '{3, 1'b1, 4'h2, 80'hFFFF_FFFF_FFFF_FFFF_FF12, 5'd2, 1'b0};
        vecs[2]  = '{3, 1'b1, 4'h3, 80'hFFFF_FFFF_FFFF_FFFF_F123, 5'd3, 1'b0};
        vecs[3]  = '{3, 1'b1, 4'h4, 80'hFFFF_FFFF_FFFF_FFFF_1234, 5'd4, 1'b0};
        vecs[4]  = '{2, 1'b1, 4'hC, 80'hFFFF_FFFF_FFFF_FFFF_1234, 5'd4, 1'b0};
        vecs[5]  = '{0, 1'b1, 4'hF, 80'hFFFF_FFFF_FFFF_FFFF_1234, 5'd4, 1'b0};
        vecs[6]  = '{1, 1'b1, 4'hA, 80'hFFFF_FFFF_FFFF_FFFF_1234, 5'd4, 1'b1};
        vecs[7]  = '{0, 1'b0, 4'h0, ALL_F, 5'd0, 1'b0};
        vecs[8]  = '{2, 1'b1, 4'h5, 80'hFFFF_FFFF_FFFF_FFFF_FFF5, 5'd1, 1'b0};
        vecs[9]  = '{2, 1'b1, 4'h0, 80'hFFFF_FFFF_FFFF_FFFF_FF50, 5'd2, 1'b0};
        vecs[10] = '{2, 1'b1, 4'hA, 80'hFFFF_FFFF_FFFF_FFFF_FF50, 5'd2, 1'b1};
        vecs[11] = '{0, 1'b0, 4'h0, ALL_F, 5'd0, 1'b0};
        vecs[12] = '{2, 1'b1, 4'hA, ALL_F, 5'd0, 1'b1};
        vecs[13] = '{0, 1'b0, 4'h0, ALL_F, 5'd0, 1'b0};
        vecs[14] = '{2, 1'b1, 4'h8, 80'hFFFF_FFFF_FFFF_FFFF_FFF8, 5'd1, 1'b0};
        vecs[15] = '{2, 1'b1, 4'h9, 80'hFFFF_FFFF_FFFF_FFFF_FF89, 5'd2, 1'b0};
        vecs[16] = '{2, 1'b1, 4'hB, ALL_B, 5'd2, 1'b1};
        vecs[17] = '{0, 1'b0, 4'h0, ALL_F, 5'd0, 1'b0};

        rst       = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (3) @(negedge clk);
        check_all("reset", ALL_F, 5'd0, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            repeat (vecs[i].gap) @(negedge clk);
            if (vecs[i].press) press(vecs[i].code);
            else @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].val, vecs[i].cnt, vecs[i].vld);
        end

        // Key arriving during EMIT is dropped.
        press(4'h1);
        press(4'hA);
        check_all("emit_pulse", 80'hFFFF_FFFF_FFFF_FFFF_FFF1, 5'd1, 1'b1);
        key_valid = 1'b1;
        key_code  = 4'h5;
        @(negedge clk);
        key_valid = 1'b0;
        check_all("emit_drop", ALL_F, 5'd0, 1'b0);

        // Timeout: pulse exactly T cycles after the acceptance edge.
        repeat (2) @(negedge clk);
        press(4'h7);
        for (int k = 1; k < T; k++) begin
            @(negedge clk);
            check($sformatf("to_quiet%0d", k), 80'(digitos_valid), 80'd0);
        end
        @(negedge clk);
        check_all("timeout", ALL_E, 5'd1, 1'b1);
        @(negedge clk);
        check_all("timeout_clear", ALL_F, 5'd0, 1'b0);

        // Key in the expiry cycle wins over the timeout and re-arms it.
        repeat (2) @(negedge clk);
        press(4'h7);
        repeat (T - 2) @(negedge clk);
        press(4'h3);
        check_all("to_prio", 80'hFFFF_FFFF_FFFF_FFFF_FF73, 5'd2, 1'b0);
        repeat (T - 1) @(negedge clk);
        check("to_rearm_quiet", 80'(digitos_valid), 80'd0);
        @(negedge clk);
        check_all("to_rearm", ALL_E, 5'd2, 1'b1);
        @(negedge clk);

        // Saturation: 22 digits, last 20 kept.
        for (int k = 0; k < 22; k++) begin
            press(4'((k < 20) ? (k % 10) : (k - 19)));
            if (k == 19) check("sat_cnt20", 80'(digit_count), 80'd20);
        end
        check_all("sat_buf", 80'h2345_6789_0123_4567_8912, 5'd20, 1'b0);
        press(4'hA);
        check_all("sat_emit", 80'h2345_6789_0123_4567_8912, 5'd20, 1'b1);
        @(negedge clk);

        // Asynchronous reset mid-entry, between clock edges.
        press(4'h1);
        press(4'h2);
        press(4'h3);
        check("pre_rst", digitos_value, 80'hFFFF_FFFF_FFFF_FFFF_F123);
        #2 rst = 1'b0;
        #1 check_all("async_rst", ALL_F, 5'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Reset during EMIT loses the pulse.
        press(4'h4);
        press(4'hB);
        #1 rst = 1'b0;
        #1 check_all("rst_emit", ALL_F, 5'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all("post_rst", ALL_F, 5'd0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/teclado_digitos.md
Name: teclado_digitos

Overview:
- Keypad digit accumulator directly upstream of the setup/configuration FSM and the password checker.
- Collects decoded keypad codes into a 20-digit BCD buffer, presented live as digitos_value.
- Issues a one-cycle digitos_valid pulse on confirm, cancel or inactivity timeout, using sentinel patterns all-F (empty confirm), all-B (cancel/exit) and all-E (timeout).

Parameters:
- TIMEOUT_CYCLES, 250_000_000: idle clocks in ENTRY before the buffer is abandoned (5 s at 50 MHz).
- MAX_DIGITS, 20: buffer depth in digits; must equal the senhaPac_t digit count.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe from the debounced keypad decoder.
- key_code  in  4  0x0-0x9 digit, 0xA confirm ('*'), 0xB cancel ('#'), 0xC-0xF ignored.
- digitos_value  out  senhaPac_t (80)  digits[0] = newest digit, unused positions 0xF.
- digitos_valid  out  1  one-cycle pulse: digitos_value is a final entry.
- digit_count  out  5  number of digits currently buffered, 0..20.

Behaviour:
- Reset (rst low, async): state IDLE, buffer all 0xF, digitos_valid 0, digit_count 0, timeout counter 0. All outputs are registered.
- States: IDLE (buffer empty), ENTRY (1..20 digits held), EMIT (one-cycle output of a final value).
- Digit key (0-9), accepted in IDLE or ENTRY:
  - Buffer shifts up by one: digits[i] <= digits[i-1], digits[0] <= key_code.
  - digit_count increments, saturating at 20.
  - When 20 digits are already held, the oldest (digits[19]) is discarded.
  - Next state ENTRY; timeout counter cleared.
  - digitos_value shows the new buffer on the edge after the strobe (latency 1).
- Confirm (0xA):
  - From ENTRY: EMIT with digitos_value = buffer.
  - From IDLE: EMIT with digitos_value = all 0xF (the "keep current value" request).
- Cancel (0xB), from IDLE or ENTRY: EMIT with digitos_value = all 0xB.
- Codes 0xC-0xF: ignored entirely. No state change, counter not cleared.
- EMIT (exactly one cycle):
  - digitos_valid = 1 while in EMIT.
  - Next edge: buffer all 0xF, digit_count 0, state IDLE, digitos_valid 0.
  - A key_valid arriving during EMIT is dropped; the decoder's minimum key spacing is well above 2 cycles.
- Timeout:
  - In ENTRY, the counter increments every cycle without an accepted key.
  - When it reaches TIMEOUT_CYCLES-1: EMIT with digitos_value = all 0xE, buffer discarded.
  - The counter is held at 0 in IDLE and EMIT.
- Simultaneous events: a key_valid in the same cycle the counter expires takes priority (key processed, counter cleared, no timeout).
- digitos_valid is never asserted outside EMIT. No two valid pulses occur on consecutive cycles.
- Counter width: clog2(TIMEOUT_CYCLES)+1 bits; no wrap-around is possible because expiry forces a state exit.
- Reset mid-entry or mid-EMIT: immediate return to reset values; a pending pulse is lost.

Test Plan:
- Reset, then keys 1,2,3,4 each 4 cycles apart:
  - After each strobe+1 cycle, digitos_value shows ...F1, ...F12, ...F123, ...F1234 (digits[0] = 4).
  - digit_count = 4; valid stays 0.
- Keys 5,0 then 0xA:
  - Exactly one cycle with valid = 1 and digits[1:0] = {5,0}, rest 0xF.
  - Next cycle: value all 0xF, count 0.
- 0xA from IDLE -> one valid pulse with all 0xF. 0xB after two digits -> one valid pulse with all 0xB, buffer cleared.
- TIMEOUT_CYCLES = 16; key 7, then no keys:
  - Valid pulses with all 0xE exactly 16 cycles after the strobe's acceptance edge.
  - Key 3 entered at cycle 15 instead -> no timeout, buffer ...F73.
- 22 digit keys 0..9,0..9,1,2 then 0xA:
  - Emitted digits[19:0] hold the last 20 digits entered.
  - digit_count saturates at 20.
- rst pulled low while 3 digits are buffered -> outputs return to reset values asynchronously. Key 0xC/0xF strobes -> no change.
